// File: rtl/pfb_multichannel_interpolator.sv
// Polyphase multichannel interpolator.
// Each accepted sample is shifted into the history of its channel, then
// L outputs are produced, one per polyphase branch p. Each output is the
// TAPS-deep dot product sum_k x[c][k] * h[k*L + p], computed serially with
// one shared multiplier. It is then rounded, shifted and saturated.
// Coefficients are writable only while the block is idle.

module pfb_multichannel_interpolator #(
    parameter int NUM_CH    = 4,
    parameter int L         = 4,
    parameter int TAPS      = 4,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int ACC_W     = 36,
    parameter int OUT_SHIFT = 15,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PH_W     = (L > 1) ? $clog2(L) : 1,
    localparam int CA_W     = (L * TAPS > 1) ? $clog2(L * TAPS) : 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout,
    output logic [CH_W-1:0]   dout_ch,
    output logic [PH_W-1:0]   dout_phase,
    output logic              dout_valid,
    input  logic              dout_ready,
    input  logic              coef_we,
    input  logic [CA_W-1:0]   coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              coef_busy
);

    localparam int K_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int NCOEF  = L * TAPS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [CH_W-1:0]         ch_reg;
    logic [PH_W-1:0]         phase_reg;
    logic [K_W-1:0]          tap_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [DATA_W-1:0]       dout_reg;
    logic [CH_W-1:0]         dout_ch_reg;
    logic [PH_W-1:0]         dout_phase_reg;
    logic                    dout_valid_reg;
    logic                    din_ready_reg;
    logic                    coef_busy_reg;

    // History and coefficient storage are plain registers because reset must clear them
    logic [NUM_CH-1:0][TAPS-1:0][DATA_W-1:0] hist_reg;
    logic [NUM_CH-1:0][TAPS-1:0][DATA_W-1:0] hist_next;
    logic [NCOEF-1:0][COEF_W-1:0]            coef_reg;
    logic [NCOEF-1:0][COEF_W-1:0]            coef_next;

    logic                    accept;
    logic                    coef_wr;
    logic [CA_W-1:0]         coef_idx;
    logic signed [DATA_W-1:0] x_sel;
    logic signed [COEF_W-1:0] h_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] rnd_add;
    logic signed [ACC_W-1:0] rnd_sum;
    logic signed [ACC_W-1:0] shifted;
    logic [ACC_W-DATA_W:0]   upper;
    logic                    in_range;
    logic [DATA_W-1:0]       sat_val;

    assign accept  = (state_reg == IDLE) && din_valid;
    assign coef_wr = (state_reg == IDLE) && coef_we;

    // Delay line: on accept, the current channel shifts its history by one slot
    genvar gi, gk;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            for (gk = 0; gk < TAPS; gk++) begin : g_tap
                if (gk == 0) begin : g_head
                    assign hist_next[gi][gk] = (accept && ch_reg == CH_W'(gi)) ? din : hist_reg[gi][gk];
                end else begin : g_body
                    assign hist_next[gi][gk] = (accept && ch_reg == CH_W'(gi)) ? hist_reg[gi][gk-1]
                                                                               : hist_reg[gi][gk];
                end
            end
        end
    endgenerate

    // Coefficient bank: one write-enable decode per entry
    generate
        for (gi = 0; gi < NCOEF; gi++) begin : g_coef
            assign coef_next[gi] = (coef_wr && coef_addr == CA_W'(gi)) ? coef_data : coef_reg[gi];
        end
    endgenerate

    // Storage update for history and coefficients
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            hist_reg <= '0;
            coef_reg <= '0;
        end else begin
            hist_reg <= hist_next;
            coef_reg <= coef_next;
        end
    end

    // Shared MAC datapath: tap k of branch p uses coefficient k*L + p
    assign coef_idx = CA_W'(tap_reg) * CA_W'(L) + CA_W'(phase_reg);
    assign x_sel    = $signed(hist_reg[ch_reg][tap_reg]);
    assign h_sel    = $signed(coef_reg[coef_idx]);
    assign prod     = x_sel * h_sel;
    assign acc_next = acc_reg + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // Round half up, then arithmetic shift, then clamp to the output range
    assign rnd_add  = {{(ACC_W - 1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
    assign rnd_sum  = acc_reg + rnd_add;
    assign shifted  = rnd_sum >>> OUT_SHIFT;
    assign upper    = shifted[ACC_W-1:DATA_W-1];
    assign in_range = (&upper) || (~|upper);
    assign sat_val  = in_range ? shifted[DATA_W-1:0]
                    : (shifted[ACC_W-1] ? {1'b1, {(DATA_W - 1){1'b0}}}
                                        : {1'b0, {(DATA_W - 1){1'b1}}});

    // Control FSM with registered handshake and output signals
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg      <= IDLE;
            ch_reg         <= '0;
            phase_reg      <= '0;
            tap_reg        <= '0;
            acc_reg        <= '0;
            dout_reg       <= '0;
            dout_ch_reg    <= '0;
            dout_phase_reg <= '0;
            dout_valid_reg <= 1'b0;
            din_ready_reg  <= 1'b1;
            coef_busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (din_valid) begin
                        state_reg     <= MAC;
                        phase_reg     <= '0;
                        tap_reg       <= '0;
                        acc_reg       <= '0;
                        din_ready_reg <= 1'b0;
                        coef_busy_reg <= 1'b1;
                    end
                end
                MAC: begin
                    acc_reg <= acc_next;
                    if (tap_reg == K_W'(TAPS - 1)) begin
                        tap_reg   <= '0;
                        state_reg <= OUT;
                    end else begin
                        tap_reg <= tap_reg + K_W'(1);
                    end
                end
                OUT: begin
                    if (!dout_valid_reg) begin
                        dout_reg       <= sat_val;
                        dout_ch_reg    <= ch_reg;
                        dout_phase_reg <= phase_reg;
                        dout_valid_reg <= 1'b1;
                    end else if (dout_ready) begin
                        dout_valid_reg <= 1'b0;
                        if (phase_reg == PH_W'(L - 1)) begin
                            state_reg     <= IDLE;
                            din_ready_reg <= 1'b1;
                            coef_busy_reg <= 1'b0;
                            ch_reg        <= (ch_reg == CH_W'(NUM_CH - 1)) ? '0 : ch_reg + CH_W'(1);
                        end else begin
                            state_reg <= MAC;
                            phase_reg <= phase_reg + PH_W'(1);
                            tap_reg   <= '0;
                            acc_reg   <= '0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign din_ready  = din_ready_reg;
    assign dout       = dout_reg;
    assign dout_ch    = dout_ch_reg;
    assign dout_phase = dout_phase_reg;
    assign dout_valid = dout_valid_reg;
    assign coef_busy  = coef_busy_reg;

endmodule
